// File: rtl/mem_bus_pkg.sv
// Shared types for the multiplexed-bus memory controller: FSM state encoding,
// CPU status encodings and a small status decode helper.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
  } bus_state_e;

  localparam logic [1:0] STAT_FETCH = 2'b11;
  localparam logic [1:0] STAT_READ  = 2'b10;
  localparam logic [1:0] STAT_WRITE = 2'b01;

  function automatic logic is_fetch(input logic [1:0] status);
    return (status == STAT_FETCH);
  endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Byte-wide storage behind the bus controller: synchronous write, combinational
// read, no reset so contents survive a controller reset.
module mem_bus_ram #(
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory controller for an 8085-style multiplexed AD bus with optional wait states.
// Define MEM_BUS_WAIT_EN to honour WAIT_STATES; otherwise READY is tied high.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          MEM_AW      = 10,
  parameter logic [15:0] MEM_BASE    = 16'h0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic       ALE,
  input  logic [7:0] ADD,
  inout  wire  [7:0] DATA,
  input  logic       RDn,
  input  logic       WRn,
  input  logic       IO_Mn,
  input  logic       S0,
  input  logic       S1,
  output logic       READY,
  output logic       fetch_cycle
);

`ifdef MEM_BUS_WAIT_EN
  localparam logic WAIT_EN_C = 1'b1;
`else
  localparam logic WAIT_EN_C = 1'b0;
`endif

  localparam logic       USE_WAIT_C = WAIT_EN_C && (WAIT_STATES != 0);
  localparam logic [2:0] WS_LOAD_C  = 3'(WAIT_STATES - 1);

  bus_state_e  state_r, next_state_s;
  logic [15:0] addr_r;
  logic [1:0]  status_r, status_next_s;
  logic [2:0]  count_r, count_next_s;
  logic [7:0]  data_hold_r;
  logic        wrn_prev_r;
  logic        is_write_r, is_write_next_s;
  logic        ready_r;
  logic        fetch_r;
  logic        hit_s;
  logic        strobe_one_s;
  logic        commit_s;
  logic        mem_we_s;
  logic        drive_s;
  logic [7:0]  rd_data_s;

  assign hit_s         = !IO_Mn && (addr_r[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
  assign strobe_one_s  = RDn ^ WRn;
  assign status_next_s = ALE ? {S1, S0} : status_r;
  // A write lands only on the WRn rising edge, and never when aborted by ALE or reset
  assign commit_s      = (state_r == ST_ACCESS) && is_write_r && WRn && !wrn_prev_r;
  assign mem_we_s      = commit_s && !ALE && !reset_in;
  assign drive_s       = (state_r == ST_ACCESS) && !is_write_r && !RDn && !ALE;

  assign DATA        = drive_s ? rd_data_s : 8'hzz;
  assign READY       = WAIT_EN_C ? ready_r : 1'b1;
  assign fetch_cycle = fetch_r;

  mem_bus_ram #(.AW(MEM_AW)) u_ram (
    .clock (clock),
    .we    (mem_we_s),
    .addr  (addr_r[MEM_AW-1:0]),
    .wdata (data_hold_r),
    .rdata (rd_data_s)
  );

  // Next-state and wait-counter logic; ALE restarts from any state
  always_comb begin
    next_state_s    = state_r;
    count_next_s    = count_r;
    is_write_next_s = is_write_r;
    if (ALE) begin
      next_state_s = ST_ADDR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_IDLE;
        end
        ST_ADDR: begin
          if (hit_s && strobe_one_s) begin
            is_write_next_s = !WRn;
            if (USE_WAIT_C) begin
              next_state_s = ST_WAIT;
              count_next_s = WS_LOAD_C;
            end else begin
              next_state_s = ST_ACCESS;
            end
          end else begin
            next_state_s = ST_ADDR;
          end
        end
        ST_WAIT: begin
          if (count_r == 3'd0) begin
            next_state_s = ST_ACCESS;
          end else begin
            next_state_s = ST_WAIT;
            count_next_s = count_r - 3'd1;
          end
        end
        ST_ACCESS: begin
          if (is_write_r) begin
            if (commit_s) begin
              next_state_s = ST_DONE;
            end else begin
              next_state_s = ST_ACCESS;
            end
          end else begin
            if (RDn) begin
              next_state_s = ST_DONE;
            end else begin
              next_state_s = ST_ACCESS;
            end
          end
        end
        ST_DONE: begin
          next_state_s = ST_IDLE;
        end
        default: begin
          next_state_s = ST_IDLE;
          count_next_s = 3'd0;
        end
      endcase
    end
  end

  // State, latched address/status, write holding register and registered outputs
  always_ff @(posedge clock) begin
    if (reset_in) begin
      state_r     <= ST_IDLE;
      addr_r      <= 16'h0000;
      status_r    <= 2'b00;
      count_r     <= 3'd0;
      data_hold_r <= 8'h00;
      wrn_prev_r  <= 1'b1;
      is_write_r  <= 1'b0;
      ready_r     <= 1'b1;
      fetch_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      count_r    <= count_next_s;
      is_write_r <= is_write_next_s;
      wrn_prev_r <= WRn;
      status_r   <= status_next_s;
      if (ALE) begin
        addr_r <= {ADD, DATA};
      end
      if ((state_r == ST_ACCESS) && is_write_r && !WRn) begin
        data_hold_r <= DATA;
      end
      ready_r <= (next_state_s != ST_WAIT);
      fetch_r <= ((next_state_s == ST_ADDR) || (next_state_s == ST_WAIT) ||
                  (next_state_s == ST_ACCESS)) && is_fetch(status_next_s);
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: table of per-cycle bus vectors plus
// hand-written sequences for reset abort, ALE abort and a 3-wait-state instance.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

`ifdef MEM_BUS_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct {
    logic       ale;
    logic [7:0] add;
    logic [7:0] lo;
    logic       drv;
    logic       rdn;
    logic       wrn;
    logic       iom;
    logic [1:0] st;
    logic       wt;
    logic       er;
    logic       ed;
    logic [7:0] edata;
    logic       ef;
  } vec_t;

  vec_t vq[$];

  logic       clock = 1'b0;
  logic       reset_in;
  logic       ale;
  logic [7:0] add;
  logic [7:0] tb_val;
  logic       tb_oe;
  logic       rdn, wrn, iom, s0, s1;
  wire  [7:0] data1, data2;
  logic       ready1, ready2, fetch1, fetch2;
  int         n_err = 0;
  int         n_chk = 0;

  assign data1 = tb_oe ? tb_val : 8'hzz;
  assign data2 = tb_oe ? tb_val : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu1 (data1[i]);
    pullup pu2 (data2[i]);
  end

  always #5 clock = ~clock;

  mem_bus_ctrl #(.MEM_AW(10), .MEM_BASE(16'h0000), .WAIT_STATES(1)) dut1 (
    .clock(clock), .reset_in(reset_in), .ALE(ale), .ADD(add), .DATA(data1),
    .RDn(rdn), .WRn(wrn), .IO_Mn(iom), .S0(s0), .S1(s1),
    .READY(ready1), .fetch_cycle(fetch1)
  );

  mem_bus_ctrl #(.MEM_AW(10), .MEM_BASE(16'h0000), .WAIT_STATES(3)) dut2 (
    .clock(clock), .reset_in(reset_in), .ALE(ale), .ADD(add), .DATA(data2),
    .RDn(rdn), .WRn(wrn), .IO_Mn(iom), .S0(s0), .S1(s1),
    .READY(ready2), .fetch_cycle(fetch2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic a, input logic [7:0] hi, input logic [7:0] lo,
                               input logic drv, input logic rd, input logic wr, input logic io,
                               input logic [1:0] st, input logic wt, input logic er,
                               input logic ed, input logic [7:0] edata, input logic ef);
    vec_t v;
    v.ale = a;   v.add = hi;  v.lo = lo;  v.drv = drv; v.rdn = rd; v.wrn = wr;
    v.iom = io;  v.st = st;   v.wt = wt;  v.er = er;   v.ed = ed;  v.edata = edata;
    v.ef = ef;
    vq.push_back(v);
  endfunction

  function automatic void add_write(input logic [7:0] hi, input logic [7:0] lo,
                                    input logic [7:0] d, input logic io, input logic hit);
    push(1'b1, hi, lo, 1'b1, 1'b1, 1'b1, io, STAT_WRITE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    if (hit) push(1'b0, 8'h00, d, 1'b1, 1'b1, 1'b0, io, STAT_WRITE, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    push(1'b0, 8'h00, d, 1'b1, 1'b1, 1'b0, io, STAT_WRITE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    push(1'b0, 8'h00, d, 1'b1, 1'b1, 1'b0, io, STAT_WRITE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    push(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, io, STAT_WRITE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    push(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, io, STAT_WRITE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endfunction

  function automatic void add_read(input logic [7:0] hi, input logic [7:0] lo, input logic io,
                                   input logic [1:0] st, input logic hit, input logic [7:0] exp);
    logic f;
    logic fe;
    f  = (st == 2'b11);
    fe = hit ? 1'b0 : f;
    push(1'b1, hi, lo, 1'b1, 1'b1, 1'b1, io, st, 1'b0, 1'b1, 1'b0, 8'h00, f);
    if (hit) push(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, io, st, 1'b1, 1'b0, 1'b0, 8'h00, f);
    push(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, io, st, 1'b0, 1'b1, hit, exp, f);
    push(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, io, st, 1'b0, 1'b1, hit, exp, f);
    push(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, io, st, 1'b0, 1'b1, 1'b0, 8'h00, fe);
    push(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, io, st, 1'b0, 1'b1, 1'b0, 8'h00, fe);
  endfunction

  task automatic drive_bus(input logic a, input logic [7:0] hi, input logic [7:0] lo,
                           input logic drv, input logic rd, input logic wr, input logic io,
                           input logic [1:0] st);
    ale = a; add = hi; tb_val = lo; tb_oe = drv; rdn = rd; wrn = wr; iom = io;
    s1 = st[1]; s0 = st[0];
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    drive_bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, STAT_READ);
    @(posedge clock); #1;
  endtask

  task automatic do_read(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] exp,
                         input string name);
    @(negedge clock);
    drive_bus(1'b1, hi, lo, 1'b1, 1'b1, 1'b1, 1'b0, STAT_READ);
    @(negedge clock);
    drive_bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, STAT_READ);
    repeat (WAIT_EN ? 2 : 1) @(posedge clock);
    #1;
    chk(name, 32'(data1), 32'(exp));
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_r;

    // Stimulus table
    add_write(8'h01, 8'h02, 8'h5A, 1'b0, 1'b1);
    add_read (8'h01, 8'h02, 1'b0, STAT_READ, 1'b1, 8'h5A);
    add_write(8'h00, 8'h00, 8'h33, 1'b0, 1'b1);
    add_write(8'h04, 8'h00, 8'hC3, 1'b0, 1'b0);
    add_write(8'h00, 8'h00, 8'hE7, 1'b1, 1'b0);
    add_read (8'h04, 8'h00, 1'b0, STAT_READ, 1'b0, 8'h00);
    add_read (8'h00, 8'h00, 1'b1, STAT_READ, 1'b0, 8'h00);
    add_read (8'h00, 8'h00, 1'b0, STAT_READ, 1'b1, 8'h33);
    add_write(8'h01, 8'h00, 8'h81, 1'b0, 1'b1);
    add_read (8'h01, 8'h00, 1'b0, STAT_FETCH, 1'b1, 8'h81);
    add_write(8'h01, 8'hFF, 8'h3C, 1'b0, 1'b1);

    // Reset state
    reset_in = 1'b1;
    drive_bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, STAT_READ);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(ready1), 32'd1);
    chk("rst_fetch", 32'(fetch1), 32'd0);
    chk("rst_data_z", 32'(data1), 32'hFF);
    chk("rst_state", 32'(dut1.state_r), 32'(ST_IDLE));
    chk("rst_addr", 32'(dut1.addr_r), 32'h0);
    @(negedge clock);
    reset_in = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].wt && !WAIT_EN) continue;
      @(negedge clock);
      drive_bus(vq[i].ale, vq[i].add, vq[i].lo, vq[i].drv, vq[i].rdn, vq[i].wrn,
                vq[i].iom, vq[i].st);
      @(posedge clock); #1;
      exp_r = WAIT_EN ? vq[i].er : 1'b1;
      chk($sformatf("vec%0d_ready", i), 32'(ready1), 32'(exp_r));
      chk($sformatf("vec%0d_fetch", i), 32'(fetch1), 32'(vq[i].ef));
      if (vq[i].ed) begin
        chk($sformatf("vec%0d_data", i), 32'(data1), 32'(vq[i].edata));
      end else if (!vq[i].drv) begin
        chk($sformatf("vec%0d_data_z", i), 32'(data1), 32'hFF);
      end
    end

    // ALE during a read access: release immediately, new address used next
    @(negedge clock);
    drive_bus(1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, STAT_READ);
    @(negedge clock);
    drive_bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, STAT_READ);
    repeat (WAIT_EN ? 2 : 1) @(posedge clock);
    #1;
    chk("ale_abort_pre", 32'(data1), 32'h5A);
    @(negedge clock);
    drive_bus(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, STAT_READ);
    #1;
    chk("ale_abort_release", 32'(data1), 32'hFF);
    @(posedge clock); #1;
    chk("ale_abort_ready", 32'(ready1), 32'd1);
    @(negedge clock);
    drive_bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, STAT_READ);
    @(negedge clock);
    rdn = 1'b0;
    repeat (WAIT_EN ? 2 : 1) @(posedge clock);
    #1;
    chk("ale_abort_new_addr", 32'(data1), 32'h3C);
    idle_cycle();
    idle_cycle();

    // Reset in the middle of a write, coinciding with WRn rising
    @(negedge clock);
    drive_bus(1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, STAT_WRITE);
    @(negedge clock);
    drive_bus(1'b0, 8'h00, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, STAT_WRITE);
    repeat (WAIT_EN ? 3 : 2) @(posedge clock);
    @(negedge clock);
    reset_in = 1'b1;
    wrn = 1'b1;
    tb_oe = 1'b0;
    @(posedge clock); #1;
    chk("rstw_ready", 32'(ready1), 32'd1);
    chk("rstw_state", 32'(dut1.state_r), 32'(ST_IDLE));
    chk("rstw_fetch", 32'(fetch1), 32'd0);
    @(negedge clock);
    reset_in = 1'b0;
    idle_cycle();
    do_read(8'h01, 8'h02, 8'h5A, "rstw_mem_kept");

    // Three-wait-state instance: write then read 16'h0000
    @(negedge clock);
    drive_bus(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, STAT_WRITE);
    @(negedge clock);
    drive_bus(1'b0, 8'h00, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, STAT_WRITE);
    repeat (6) @(posedge clock);
    idle_cycle();
    idle_cycle();
    @(negedge clock);
    drive_bus(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, STAT_READ);
    @(negedge clock);
    drive_bus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, STAT_READ);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clock); #1;
      exp_r = !(WAIT_EN && (i <= 3));
      chk($sformatf("ws3_ready_e%0d", i), 32'(ready2), 32'(exp_r));
      chk($sformatf("ws3_data_e%0d", i), 32'(data2), exp_r ? 32'h66 : 32'hFF);
      chk($sformatf("ws3_fetch_e%0d", i), 32'(fetch2), 32'd0);
    end
    idle_cycle();
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
